// File: rtl/seg_scroll_display_if.sv
// rtl/seg_scroll_display_if.sv - digit store write port and scroll direction for seg_scroll_display
interface seg_scroll_display_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int SW = $clog2(NUM_DIGITS);

    logic          write;
    logic [SW-1:0] sel;
    logic [3:0]    num;
    logic          direction;

    modport master (output write, sel, num, direction);
    modport slave  (input  write, sel, num, direction);
endinterface

// File: rtl/seg_scroll_display.sv
// rtl/seg_scroll_display.sv - multiplexed hex 7-segment display with optional scrolling
// Scrolling is compiled in only when SEG_SCROLL_DISPLAY_SCROLL_EN is defined.
module seg_scroll_display #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int SCROLL_DIV  = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scroll_display_if.slave   bus,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int            SW       = $clog2(NUM_DIGITS);
    localparam int            RW       = $clog2(REFRESH_DIV);
    localparam logic [SW-1:0] LAST     = SW'(NUM_DIGITS - 1);
    localparam logic [SW:0]   N_W      = (SW + 1)'(NUM_DIGITS);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    logic [3:0]            r_mem [NUM_DIGITS];
    logic [RW-1:0]         r_ref_cnt;
    logic [SW-1:0]         r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_ref_tc;
    logic [SW-1:0]         w_offset;
    logic [SW:0]           w_sum;
    logic [SW:0]           w_wrap;
    logic [SW-1:0]         w_pos;
    logic [3:0]            w_digit;
    logic [6:0]            w_seg;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0:    hex_decode = 7'b1000000;
            4'h1:    hex_decode = 7'b1111001;
            4'h2:    hex_decode = 7'b0100100;
            4'h3:    hex_decode = 7'b0110000;
            4'h4:    hex_decode = 7'b0011001;
            4'h5:    hex_decode = 7'b0010010;
            4'h6:    hex_decode = 7'b0000010;
            4'h7:    hex_decode = 7'b1111000;
            4'h8:    hex_decode = 7'b0000000;
            4'h9:    hex_decode = 7'b0010000;
            4'hA:    hex_decode = 7'b0001000;
            4'hB:    hex_decode = 7'b0000011;
            4'hC:    hex_decode = 7'b1000110;
            4'hD:    hex_decode = 7'b0100001;
            4'hE:    hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

    assign w_ref_tc = (r_ref_cnt == REF_LAST);

`ifdef SEG_SCROLL_DISPLAY_SCROLL_EN
    localparam int            CW       = $clog2(SCROLL_DIV);
    localparam logic [CW-1:0] SCR_LAST = CW'(SCROLL_DIV - 1);

    logic [CW-1:0] r_scr_cnt;
    logic [SW-1:0] r_offset;

    // Direction is only looked at on the scroll step itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scr_cnt <= '0;
            r_offset  <= '0;
        end else if (r_scr_cnt == SCR_LAST) begin
            r_scr_cnt <= '0;
            if (bus.direction)
                r_offset <= (r_offset == '0) ? LAST : r_offset - 1'b1;
            else
                r_offset <= (r_offset == LAST) ? '0 : r_offset + 1'b1;
        end else begin
            r_scr_cnt <= r_scr_cnt + 1'b1;
        end
    end

    assign w_offset = r_offset;
`else
    logic w_unused_dir;
    assign w_unused_dir = bus.direction;
    assign w_offset     = '0;
`endif

    // Both operands are below NUM_DIGITS, so one conditional subtract is a full modulo.
    assign w_sum  = {1'b0, r_idx} + {1'b0, w_offset};
    assign w_wrap = w_sum - N_W;
    assign w_pos  = (w_sum >= N_W) ? w_wrap[SW-1:0] : w_sum[SW-1:0];

    always_comb begin
        w_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_pos == SW'(i))
                w_digit = r_mem[i];
        end
    end

    assign w_seg = hex_decode(w_digit);

    // Out-of-range sel matches no entry, so the store is left untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                r_mem[i] <= '0;
            r_ref_cnt <= '0;
            r_idx     <= '0;
            r_seg     <= 7'b1111111;
            r_an      <= '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus.write && (bus.sel == SW'(i)))
                    r_mem[i] <= bus.num;
            end
            if (w_ref_tc) begin
                r_ref_cnt <= '0;
                r_idx     <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_seg;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
endmodule
